page_reader: RTL and testbench
==============================

PAGE_READER -- requirements
Module: page_reader

Interface
REQ-001 SHALL have parameter AW, default 16, Avalon-MM byte-address width.
REQ-002 SHALL have parameter DW, default 64, data width in bits, multiple of 8.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum burst length in words, ≥1.
REQ-004 SHALL have parameter PAGE_COUNT, default 4, number of pages; PCW = $clog2(PAGE_COUNT).
REQ-005 SHALL have parameter PAGE_SIZE, default 64, words per page.
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, output FIFO depth in words, power of 2, ≥MAX_BURST.
REQ-007 SHALL have port clock  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port start  input  1  one-cycle request to read one page.
REQ-010 SHALL have port start_page  input  PCW  page to read, sampled with start.
REQ-011 SHALL have port page_number  output  PCW  page select to the page store.
REQ-012 SHALL have port bus.address / bus.read / bus.burstcount  output  AW / 1 / $clog2(MAX_BURST)+1  Avalon-MM read command.
REQ-013 SHALL have port bus.waitrequest / bus.readdatavalid / bus.readdata  input  1 / 1 / DW  Avalon-MM response; bus.write held 0.
REQ-014 SHALL have port out_data / out_valid / out_last  output  DW / 1 / 1  output stream; out_last marks final word of page.
REQ-015 SHALL have port out_ready  input  1  downstream accept.
REQ-016 SHALL have port busy / done  output  1 / 1  page in progress / one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, REQ, RESP, DRAIN.
REQ-018 SHALL, in IDLE with start=1, latch start_page into page_number, clear word counters, go to REQ next cycle; start while not IDLE SHALL be ignored.
REQ-019 SHALL hold page_number stable from start acceptance until done.
REQ-020 SHALL, in REQ, assert bus.read only when FIFO free space ≥ outstanding words + burst length, else wait in REQ with bus.read=0.
REQ-021 SHALL use burst length = min(MAX_BURST, PAGE_SIZE − words_requested); bus.address = words_requested × DW/8.
REQ-022 SHALL hold address, burstcount, read stable while bus.waitrequest=1; command accepted in the cycle read=1 and waitrequest=0, then go to RESP.
REQ-023 SHALL, in RESP, push bus.readdata into FIFO on every bus.readdatavalid cycle; after burstcount beats, go to REQ if words_requested < PAGE_SIZE, else DRAIN.
REQ-024 SHALL never issue a second command while a burst is outstanding.
REQ-025 SHALL present FIFO head on out_data with out_valid=1 when FIFO non-empty; word popped when out_valid & out_ready; out_data/out_valid stable while out_ready=0.
REQ-026 SHALL assert out_last with the PAGE_SIZE-th word of the page only.
REQ-027 SHALL, in DRAIN, return to IDLE when the last word is popped, pulsing done for exactly that cycle; busy=1 in REQ, RESP, DRAIN.
REQ-028 SHALL support simultaneous push and pop with FIFO full; readdatavalid with FIFO full is impossible by REQ-020 and SHALL be flagged by assertion.
REQ-029 SHALL have zero-cycle FIFO bypass forbidden: first word appears on out_data one cycle after its readdatavalid.

Reset
REQ-030 SHALL, on reset_n=0, asynchronously set state IDLE, page_number 0, bus.read 0, bus.address 0, bus.burstcount 0, out_valid 0, out_last 0, busy 0, done 0, FIFO empty, counters 0.
REQ-031 SHALL discard any in-flight burst and FIFO contents on reset mid-operation; no done pulse follows.

Configuration
REQ-032 SHALL, with macro PAGE_READER_AUTO_ADVANCE_EN defined, add input run (1 bit): in DRAIN completion with run=1, page_number becomes (page_number+1) mod PAGE_COUNT and state goes to REQ next cycle; done still pulses.
REQ-033 SHALL, without PAGE_READER_AUTO_ADVANCE_EN, have no run port and read exactly one page per start.

Verification
REQ-034 start, start_page=2, out_ready=1, zero-wait slave -> 16 bursts of 4, addresses 0x000..0x1E0 step 0x20, page_number=2 throughout, 64 words, out_last on word 63, done once.
REQ-035 PAGE_SIZE=6, MAX_BURST=4 -> bursts burstcount 4 then 2, addresses 0x00 then 0x20.
REQ-036 out_ready=0 for 50 cycles after start -> exactly 8 words fetched, bus.read=0 thereafter, no overflow; resume -> all 64 words in order.
REQ-037 waitrequest=1 for 3 cycles per command -> address/burstcount/read stable those cycles, data intact.
REQ-038 reset_n=0 during RESP of burst 5 -> all outputs at reset values immediately; new start reads full page correctly.
REQ-039 AUTO_ADVANCE_EN, run=1, start_page=3 -> pages 3, 0, 1 read back-to-back, done pulse per page.

Source files
------------

// File: rtl/page_reader.sv
// Page reader: fetches one page over Avalon-MM bursts into an output FIFO and streams it out.
// Optional macro PAGE_READER_AUTO_ADVANCE_EN adds a 'run' input for back-to-back page reads.
module page_reader #(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 64,
   parameter int unsigned MAX_BURST  = 4,
   parameter int unsigned PAGE_COUNT = 4,
   parameter int unsigned PAGE_SIZE  = 64,
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned PCW = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 1,
   localparam int unsigned BCW = $clog2(MAX_BURST) + 1
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [PCW-1:0] start_page,
`ifdef PAGE_READER_AUTO_ADVANCE_EN
   input  logic           run,
`endif
   output logic [PCW-1:0] page_number,
   output logic [AW-1:0]  bus_address,
   output logic           bus_read,
   output logic           bus_write,
   output logic [BCW-1:0] bus_burstcount,
   input  logic           bus_waitrequest,
   input  logic           bus_readdatavalid,
   input  logic [DW-1:0]  bus_readdata,
   output logic [DW-1:0]  out_data,
   output logic           out_valid,
   output logic           out_last,
   input  logic           out_ready,
   output logic           busy,
   output logic           done
);

   localparam int unsigned WCW = $clog2(PAGE_SIZE + 1);
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDrain} state_e;

   state_e         state_q, state_d;
   logic [PCW-1:0] page_q, page_d;
   logic [WCW-1:0] words_req_q, words_req_d;
   logic [BCW-1:0] beats_left_q, beats_left_d;
   logic [WCW-1:0] pop_cnt_q, pop_cnt_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [DW-1:0]  mem_q [FIFO_DEPTH];

   logic [WCW-1:0] remaining;
   logic [BCW-1:0] burst_len;
   logic [CW-1:0]  free_words;
   logic           cmd_go, cmd_accept, push, pop, last_word, page_done;

   always_comb begin
      remaining  = WCW'(PAGE_SIZE) - words_req_q;
      burst_len  = (32'(remaining) > MAX_BURST) ? BCW'(MAX_BURST) : BCW'(remaining);
      free_words = CW'(FIFO_DEPTH) - fifo_cnt_q;
      // Reserve FIFO space for the whole burst so readdatavalid can never meet a full FIFO.
      cmd_go     = (state_q == StReq) &&
                   (32'(free_words) >= 32'(beats_left_q) + 32'(burst_len));
      cmd_accept = cmd_go && !bus_waitrequest;
      push       = (state_q == StResp) && bus_readdatavalid;
      pop        = (fifo_cnt_q != '0) && out_ready;
      last_word  = (fifo_cnt_q != '0) && (pop_cnt_q == WCW'(PAGE_SIZE - 1));
      page_done  = (state_q == StDrain) && pop && last_word;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         page_q       <= '0;
         words_req_q  <= '0;
         beats_left_q <= '0;
         pop_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         page_q       <= page_d;
         words_req_q  <= words_req_d;
         beats_left_q <= beats_left_d;
         pop_cnt_q    <= pop_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= bus_readdata;
   end

   always_comb begin
      state_d      = state_q;
      page_d       = page_q;
      words_req_d  = words_req_q;
      beats_left_d = beats_left_q;
      pop_cnt_d    = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               page_d      = start_page;
               words_req_d = '0;
               pop_cnt_d   = '0;
               state_d     = StReq;
            end
         end
         StReq: begin
            if (cmd_accept) begin
               words_req_d  = words_req_q + WCW'(burst_len);
               beats_left_d = burst_len;
               state_d      = StResp;
            end
         end
         StResp: begin
            if (push) begin
               beats_left_d = beats_left_q - 1'b1;
               if (beats_left_q == BCW'(1)) begin
                  state_d = (words_req_q < WCW'(PAGE_SIZE)) ? StReq : StDrain;
               end
            end
         end
         StDrain: begin
            if (page_done) begin
               state_d = StIdle;
`ifdef PAGE_READER_AUTO_ADVANCE_EN
               if (run) begin
                  page_d      = (page_q == PCW'(PAGE_COUNT - 1)) ? '0 : page_q + 1'b1;
                  words_req_d = '0;
                  pop_cnt_d   = '0;
                  state_d     = StReq;
               end
`endif
            end
         end
      endcase
   end

   always_comb begin
      bus_read       = cmd_go;
      bus_write      = 1'b0;
      bus_address    = cmd_go ? AW'(32'(words_req_q) * (DW / 8)) : '0;
      bus_burstcount = cmd_go ? burst_len : '0;
      page_number    = page_q;
      out_valid      = (fifo_cnt_q != '0);
      out_data       = mem_q[rd_ptr_q];
      out_last       = last_word;
      busy           = (state_q != StIdle);
      done           = page_done;
   end

   fifo_no_overflow_a : assert property (@(posedge clock) disable iff (!reset_n)
      !(bus_readdatavalid && (fifo_cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_page_reader.sv
// Directed bench for page_reader: vector table of page reads plus reset, short-page and
// auto-advance sequences against a small Avalon-MM slave model.
module tb_page_reader;

   logic        clock, reset_n, start;
   logic [1:0]  start_page, page_number;
   logic [15:0] bus_address;
   logic        bus_read, bus_write, bus_waitrequest, bus_readdatavalid;
   logic [2:0]  bus_burstcount;
   logic [63:0] bus_readdata, out_data;
   logic        out_valid, out_last, out_ready, busy, done;

   logic        s2_start, s2_read, s2_write, s2_wrq, s2_rdv, s2_valid, s2_last, s2_ready;
   logic        s2_busy, s2_done;
   logic [1:0]  s2_page, s2_pnum;
   logic [15:0] s2_addr;
   logic [2:0]  s2_bc;
   logic [63:0] s2_rdata, s2_data;
`ifdef PAGE_READER_AUTO_ADVANCE_EN
   logic        run, s2_run;
`endif

   page_reader dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_page(start_page),
`ifdef PAGE_READER_AUTO_ADVANCE_EN
      .run(run),
`endif
      .page_number(page_number), .bus_address(bus_address), .bus_read(bus_read),
      .bus_write(bus_write), .bus_burstcount(bus_burstcount),
      .bus_waitrequest(bus_waitrequest), .bus_readdatavalid(bus_readdatavalid),
      .bus_readdata(bus_readdata), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done)
   );

   page_reader #(.PAGE_SIZE(6), .MAX_BURST(4)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(s2_start), .start_page(s2_page),
`ifdef PAGE_READER_AUTO_ADVANCE_EN
      .run(s2_run),
`endif
      .page_number(s2_pnum), .bus_address(s2_addr), .bus_read(s2_read),
      .bus_write(s2_write), .bus_burstcount(s2_bc),
      .bus_waitrequest(s2_wrq), .bus_readdatavalid(s2_rdv),
      .bus_readdata(s2_rdata), .out_data(s2_data), .out_valid(s2_valid),
      .out_last(s2_last), .out_ready(s2_ready), .busy(s2_busy), .done(s2_done)
   );

   typedef struct {
      int pg; int ws; int stall; int rmode; int restart; int exp_cmds; int exp_fetch;
   } vec_t;

   vec_t        vecs [4];
   int          total, bad;
   int          ws, wait_cnt, beats_pend, beat_addr;
   int          n_cmds, n_beats, n_pop, idx, exp_pg, pages_seen;
   int          done_cnt, last_cnt, page_err, stab_err;
   logic        prev_wait;
   logic [15:0] held_addr;
   logic [2:0]  held_bc;
   int          s2_ncmd, s2_pend, s2_baddr, s2_pops, s2_dn;
   int          s2_a [2];
   int          s2_b [2];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk(input int pg, input int w);
      return {16'hC0DE, 16'(pg), 16'hA5A5 ^ 16'(w * 7), 16'(w)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic chki(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s act=%0d req=%0d", nm, act, req);
      end
   endtask

   task automatic chk_reset();
      chki("rst_busy", int'(busy), 0);
      chki("rst_done", int'(done), 0);
      chki("rst_read", int'(bus_read), 0);
      chki("rst_addr", int'(bus_address), 0);
      chki("rst_bc", int'(bus_burstcount), 0);
      chki("rst_valid", int'(out_valid), 0);
      chki("rst_last", int'(out_last), 0);
      chki("rst_page", int'(page_number), 0);
   endtask

   task automatic clear_counts();
      n_cmds = 0; n_beats = 0; n_pop = 0; idx = 0; pages_seen = 0;
      done_cnt = 0; last_cnt = 0; page_err = 0; stab_err = 0;
   endtask

   // One clock: drive inputs on the falling edge, model the slave, sample 1ns later.
   task automatic step(input logic rdy, input logic st, input logic [1:0] sp);
      @(negedge clock);
      out_ready = rdy;
      start     = st;
      if (st) start_page = sp;
      if (beats_pend > 0) begin
         bus_readdatavalid = 1'b1;
         bus_readdata      = mk(int'(page_number), beat_addr);
         beat_addr++; beats_pend--; n_beats++;
      end else begin
         bus_readdatavalid = 1'b0;
      end
      if (bus_read) begin
         if (prev_wait && (bus_address != held_addr || bus_burstcount != held_bc)) stab_err++;
         held_addr = bus_address;
         held_bc   = bus_burstcount;
         if (wait_cnt < ws) begin
            bus_waitrequest = 1'b1; wait_cnt++; prev_wait = 1'b1;
         end else begin
            bus_waitrequest = 1'b0; wait_cnt = 0; prev_wait = 1'b0;
            chki("cmd_addr", int'(bus_address), (n_cmds % 16) * 32);
            chki("cmd_bc", int'(bus_burstcount), 4);
            n_cmds++;
            beats_pend = int'(bus_burstcount);
            beat_addr  = int'(bus_address) / 8;
         end
      end else begin
         if (prev_wait) stab_err++;
         bus_waitrequest = 1'b0; prev_wait = 1'b0;
      end
      #1;
      if (busy && page_number != 2'(exp_pg)) page_err++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
         chk("out_data", out_data, mk(exp_pg, idx));
         chki("out_last", int'(out_last), int'(idx == 63));
         if (out_last) last_cnt++;
         n_pop++;
         if (idx == 63) begin
            idx = 0; exp_pg = (exp_pg + 1) % 4; pages_seen++;
         end else begin
            idx++;
         end
      end
   endtask

   task automatic do_abort();
      reset_n = 1'b0;
      #1;
      chk_reset();
      beats_pend = 0; bus_readdatavalid = 1'b0; bus_waitrequest = 1'b0;
      prev_wait = 1'b0; wait_cnt = 0; done_cnt = 0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) step(1'b1, 1'b0, 2'd0);
      chki("no_done_after_rst", done_cnt, 0);
      chki("empty_after_rst", int'(out_valid), 0);
   endtask

   task automatic run_page(input vec_t v, input int abort_cmd);
      int   cyc;
      logic rdy;
      ws = v.ws; exp_pg = v.pg;
      clear_counts();
      step(v.stall == 0, 1'b1, 2'(v.pg));
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         rdy = (cyc < v.stall) ? 1'b0 : ((v.rmode != 0) ? cyc[0] : 1'b1);
         step(rdy, v.restart != 0 && cyc == 10, 2'((v.pg + 1) % 4));
         if (v.stall > 0 && cyc == v.stall - 1) begin
            chki("stall_fetch", n_beats, v.exp_fetch);
            chki("stall_read", int'(bus_read), 0);
         end
         if (abort_cmd > 0 && n_cmds == abort_cmd && beats_pend == 2) begin
            do_abort();
            return;
         end
         cyc++;
      end
      repeat (4) step(1'b1, 1'b0, 2'd0);
      chki("done_once", done_cnt, 1);
      chki("words", n_pop, 64);
      chki("cmds", n_cmds, v.exp_cmds);
      chki("last_once", last_cnt, 1);
      chki("page_hold", page_err, 0);
      chki("cmd_stable", stab_err, 0);
      chki("idle_after", int'(busy), 0);
   endtask

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; start = 1'b0; start_page = 2'd0; out_ready = 1'b0;
      bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0; bus_readdata = '0;
      s2_start = 1'b0; s2_page = 2'd0; s2_wrq = 1'b0; s2_rdv = 1'b0; s2_rdata = '0;
      s2_ready = 1'b1;
`ifdef PAGE_READER_AUTO_ADVANCE_EN
      run = 1'b0; s2_run = 1'b0;
`endif
      ws = 0; wait_cnt = 0; beats_pend = 0; beat_addr = 0; prev_wait = 1'b0;
      held_addr = '0; held_bc = '0; exp_pg = 0;
      clear_counts();

      vecs[0] = '{pg: 2, ws: 0, stall: 0,  rmode: 0, restart: 0, exp_cmds: 16, exp_fetch: 0};
      vecs[1] = '{pg: 1, ws: 3, stall: 0,  rmode: 0, restart: 0, exp_cmds: 16, exp_fetch: 0};
      vecs[2] = '{pg: 0, ws: 0, stall: 50, rmode: 0, restart: 0, exp_cmds: 16, exp_fetch: 8};
      vecs[3] = '{pg: 3, ws: 1, stall: 0,  rmode: 1, restart: 1, exp_cmds: 16, exp_fetch: 0};

      repeat (3) @(negedge clock);
      chk_reset();
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 4; i++) run_page(vecs[i], 0);

      // Reset in the middle of the fifth burst, then a clean full page.
      run_page(vecs[0], 5);
      run_page('{pg: 1, ws: 0, stall: 0, rmode: 0, restart: 0, exp_cmds: 16, exp_fetch: 0}, 0);

      // Short page: burst lengths 4 then 2.
      s2_ncmd = 0; s2_pend = 0; s2_baddr = 0; s2_pops = 0; s2_dn = 0;
      s2_a[0] = -1; s2_a[1] = -1; s2_b[0] = -1; s2_b[1] = -1;
      @(negedge clock);
      s2_start = 1'b1; s2_page = 2'd1;
      repeat (40) begin
         @(negedge clock);
         s2_start = 1'b0;
         if (s2_pend > 0) begin
            s2_rdv = 1'b1; s2_rdata = mk(int'(s2_pnum), s2_baddr); s2_baddr++; s2_pend--;
         end else begin
            s2_rdv = 1'b0;
         end
         if (s2_read) begin
            if (s2_ncmd < 2) begin
               s2_a[s2_ncmd] = int'(s2_addr); s2_b[s2_ncmd] = int'(s2_bc);
            end
            s2_ncmd++;
            s2_pend = int'(s2_bc); s2_baddr = int'(s2_addr) / 8;
         end
         #1;
         if (s2_valid) begin
            chk("s2_data", s2_data, mk(1, s2_pops));
            chki("s2_last", int'(s2_last), int'(s2_pops == 5));
            s2_pops++;
         end
         if (s2_done) s2_dn++;
      end
      chki("s2_cmds", s2_ncmd, 2);
      chki("s2_addr0", s2_a[0], 0);
      chki("s2_bc0", s2_b[0], 4);
      chki("s2_addr1", s2_a[1], 32);
      chki("s2_bc1", s2_b[1], 2);
      chki("s2_words", s2_pops, 6);
      chki("s2_done", s2_dn, 1);

`ifdef PAGE_READER_AUTO_ADVANCE_EN
      ws = 0; exp_pg = 3;
      clear_counts();
      run = 1'b1;
      step(1'b1, 1'b1, 2'd3);
      for (int c = 0; c < 1000 && done_cnt < 3; c++) begin
         step(1'b1, 1'b0, 2'd0);
         if (n_cmds >= 33) run = 1'b0;
      end
      repeat (4) step(1'b1, 1'b0, 2'd0);
      chki("auto_done", done_cnt, 3);
      chki("auto_pages", pages_seen, 3);
      chki("auto_page_seq", page_err, 0);
      chki("auto_idle", int'(busy), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
